pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RV32I core. Decides each cycle whether the PC and IF/ID register advance, hold, or are flushed. It also produces ID/EX bubble and global-hold controls. Sources are load-use hazards, taken branches/jumps resolved in EX, instruction-fetch misses and data-memory back-pressure. Saturating counters expose stall and flush statistics.

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline control for the 5-stage RV32I core. Each cycle it decides whether the PC and IF/ID
// advance, hold or flush, and whether ID/EX takes a bubble or the back end freezes.
// Hazard sources: load-use, EX-resolved redirects, fetch misses and data-memory back-pressure.
// Control outputs are combinational; statistics counters saturate at all-ones.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_rs1/id_rs2              source registers of the instruction in ID
//   id_uses_rs1/id_uses_rs2    ID instruction actually reads that source
//   ex_rd, ex_mem_read         destination / is-load of the instruction in EX
//   ex_redirect                one-cycle pulse: taken branch or jump resolved in EX
//   imem_ready                 fetch data valid this cycle
//   dmem_busy                  data memory stalled, freeze the whole pipeline
//   pc_en, if_id_en            PC and IF/ID load enables
//   if_id_flush, id_ex_flush   load NOP / bubble into IF/ID and ID/EX
//   pipe_hold                  freeze ID/EX, EX/MEM, MEM/WB
//   stall_cycles               cycles with pc_en=0 (saturating)
//   flush_events               redirects applied (saturating)
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {StRun, StHold} state_e;

    state_e            state_q;
    logic              pend_redirect_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic load_use;
    logic redir;
    logic apply_redir;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // A pending redirect is only ever captured during a busy cycle, so it can only be
    // observed while the FSM sits in HOLD.
    assign redir       = ex_redirect || (pend_redirect_q && (state_q == StHold));
    assign apply_redir = !reset && !dmem_busy && redir;

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (dmem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            pipe_hold = 1'b1;
        end else if (redir) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            // Bubble into ID; if_id_en stays high so the flush is actually loaded.
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StRun;
            pend_redirect_q <= 1'b0;
            stall_q         <= '0;
            flush_q         <= '0;
        end else begin
            state_q <= dmem_busy ? StHold : StRun;
            if (dmem_busy) begin
                if (ex_redirect) begin
                    pend_redirect_q <= 1'b1;
                end
            end else if (redir) begin
                pend_redirect_q <= 1'b0;
            end
            if (!pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (apply_redir && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, imem_ready, dmem_busy;
    logic       pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_hold;
    logic [15:0] stall_cycles, flush_events;
    logic       s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush, s_pipe_hold;
    logic [3:0] s_stall_cycles, s_flush_events;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
        .dmem_busy(dmem_busy), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pipe_hold(pipe_hold),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
        .dmem_busy(dmem_busy), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .pipe_hold(s_pipe_hold),
        .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctrl = {pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_hold}
    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       mr, rdr, imem, busy;
        logic [4:0] ctrl;
        int         stall, flush;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic u1,
                                logic u2, logic [4:0] rd, logic mr, logic rdr, logic imem,
                                logic busy, logic [4:0] ctrl, int stall, int flush);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mr = mr; v.rdr = rdr; v.imem = imem; v.busy = busy; v.ctrl = ctrl;
        v.stall = stall; v.flush = flush;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Inputs applied 1 time unit after a rising edge; outputs sampled mid-cycle,
    // counters sampled 1 unit after the closing edge.
    task automatic run_vec(vec_t v, string tag);
        reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1;
        id_uses_rs2 = v.u2; ex_rd = v.rd; ex_mem_read = v.mr; ex_redirect = v.rdr;
        imem_ready = v.imem; dmem_busy = v.busy;
        #4;
        chk({tag, ".ctrl"}, int'({pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_hold}),
            int'(v.ctrl));
        @(posedge clk);
        #1;
        chk({tag, ".stall"}, int'(stall_cycles), v.stall);
        chk({tag, ".flush"}, int'(flush_events), v.flush);
    endtask

    localparam logic [4:0] C_RST  = 5'b00110;
    localparam logic [4:0] C_RUN  = 5'b11000;
    localparam logic [4:0] C_LU   = 5'b00010;
    localparam logic [4:0] C_MISS = 5'b01100;
    localparam logic [4:0] C_RDR  = 5'b11110;
    localparam logic [4:0] C_HOLD = 5'b00001;

    vec_t tbl[$];

    initial begin
        reset = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs1 = 0;
        id_uses_rs2 = 0; ex_mem_read = 0; ex_redirect = 0; imem_ready = 1; dmem_busy = 0;

        //          rst rs1 rs2 u1 u2 rd mr rdr im bsy ctrl   st fl
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST,  0, 0)); // reset x2
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN,  0, 0)); // first free cycle
        tbl.push_back(mk(0, 0, 5, 0, 1, 5, 1, 0, 1, 0, C_LU,   1, 0)); // load-use rs2
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, C_RUN,  1, 0)); // rd=x0: none
        tbl.push_back(mk(0, 7, 0, 1, 0, 7, 1, 0, 1, 0, C_LU,   2, 0)); // load-use rs1
        tbl.push_back(mk(0, 7, 0, 0, 0, 7, 1, 0, 1, 0, C_RUN,  2, 0)); // rs1 not used
        tbl.push_back(mk(0, 7, 0, 1, 0, 7, 0, 0, 1, 0, C_RUN,  2, 0)); // not a load
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MISS, 3, 0)); // fetch miss
        tbl.push_back(mk(0, 0, 5, 0, 1, 5, 1, 1, 0, 0, C_RDR,  3, 1)); // redirect wins
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RDR,  3, 2)); // back-to-back
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_HOLD, 4, 2)); // busy
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_HOLD, 5, 2)); // busy+redirect
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_HOLD, 6, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RDR,  6, 3)); // pending applied
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN,  6, 3)); // only once
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_HOLD, 7, 3)); // busy+redirect
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RDR,  7, 4)); // pend+pulse: 1 count
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN,  7, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_HOLD, 8, 4)); // capture pending
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST,  0, 0)); // reset discards it
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN,  0, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Redirect during hold: busy 4 cycles, pulse in cycle 2, flush in cycle 5.
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0, 0), "hold.rst");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_HOLD, 1, 0), "hold.c1");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_HOLD, 2, 0), "hold.c2");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_HOLD, 3, 0), "hold.c3");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_HOLD, 4, 0), "hold.c4");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RDR,  4, 1), "hold.c5");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RUN,  4, 1), "hold.c6");

        // Saturation: 20 fetch-miss cycles; the 4-bit instance stops at 15.
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0, 0), "sat.rst");
        chk("sat.small_rst", int'(s_stall_cycles), 0);
        for (int i = 1; i <= 20; i++) begin
            run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MISS, i, 0), $sformatf("sat.miss%0d", i));
            chk($sformatf("sat.small%0d", i), int'(s_stall_cycles), (i > 15) ? 15 : i);
        end
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0, 0), "sat.rst2");
        chk("sat.small_clear", int'(s_stall_cycles), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
